hc_595_rx: RTL and testbench

Receive-side counterpart of the 74HC595 display link: samples the `ds`/`shcp`/`stcp`/`oe` serial lines in the `sys_clk` domain, rebuilds the 14-bit frame and presents it as parallel `sel`/`seg` with a one-cycle valid strobe. Used as a loopback checker and on-board capture block for the six-digit segment display path, so the transmitter can be verified in-system and a second board can mirror the display.

---
 rtl/hc_595_pkg.sv | 33 +++
 rtl/hc_595_rx_if.sv | 26 ++
 rtl/hc_595_rx_sync_edge.sv | 35 +++
 rtl/hc_595_rx.sv | 129 ++++++++++++
 tb/tb_hc_595_rx.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/hc_595_pkg.sv
// Shared 74HC595 link constants and frame-unpacking helpers.
package hc_595_pkg;

  localparam int unsigned FRAME_BITS = 14;
  localparam int unsigned SEL_W      = 6;
  localparam int unsigned SEG_W      = 8;
  localparam int unsigned CNT_W      = 4;

  // Wire order: sel[0] first, ..., sel[5], then seg[7] down to seg[0] last.
  // After a full frame, sel[i] sits at shreg[SEL_BASE_IDX+i] and
  // seg[SEG_W-1-i] sits at shreg[SEG_BASE_IDX+i].
  localparam int unsigned SEL_BASE_IDX = 0;
  localparam int unsigned SEG_BASE_IDX = SEL_W;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Extract digit select from the shift register image.
  function automatic logic [SEL_W-1:0] sel_from_frame(input logic [FRAME_BITS-1:0] f);
    sel_from_frame = f[SEL_BASE_IDX +: SEL_W];
  endfunction

  // Extract segment pattern; seg MSB was shifted first so the slice is bit-reversed.
  function automatic logic [SEG_W-1:0] seg_from_frame(input logic [FRAME_BITS-1:0] f);
    logic [SEG_W-1:0] s;
    s = '0;
    for (int i = 0; i < int'(SEG_W); i++) begin
      s[SEG_W-1-i] = f[SEG_BASE_IDX+i];
    end
    return s;
  endfunction

endpackage

// File: rtl/hc_595_rx_if.sv
// Serial 74HC595 lines in, rebuilt parallel frame out.
interface hc_595_rx_if;
  import hc_595_pkg::*;

  logic             ds;
  logic             shcp;
  logic             stcp;
  logic             oe;
  logic [SEL_W-1:0] sel;
  logic [SEG_W-1:0] seg;
  logic             frame_vld;
  logic             oe_act;
  logic             frame_err;

  // Transmitter / stimulus side.
  modport master (
    output ds, shcp, stcp, oe,
    input  sel, seg, frame_vld, oe_act, frame_err
  );

  // Receiver side.
  modport slave (
    input  ds, shcp, stcp, oe,
    output sel, seg, frame_vld, oe_act, frame_err
  );
endinterface

// File: rtl/hc_595_rx_sync_edge.sv
// STAGES-deep input synchronizer with synced level and rising-edge strobe.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic rise_c
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  // Next state: shift the async input in, remember the last synced level.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  // Synchronizer and previous-value flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign lvl    = sync_q[STAGES-1];
  assign rise_c = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/hc_595_rx.sv
// 74HC595 link receiver: rebuilds the 14-bit sel/seg frame from ds/shcp/stcp.
// Optional framing check enabled by defining HC595_RX_CHK_EN.
module hc_595_rx
  import hc_595_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic         sys_clk,
  input logic         sys_rst,
  hc_595_rx_if.slave  bus
);

  localparam int unsigned     ARM_W    = 3;
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  logic ds_s, shcp_s, stcp_s, oe_s;
  logic shcp_rise_c, stcp_rise_c;
  logic ds_rise_unused, oe_rise_unused;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ds (
    .clk(sys_clk), .rst(sys_rst), .d(bus.ds), .lvl(ds_s), .rise_c(ds_rise_unused)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_shcp (
    .clk(sys_clk), .rst(sys_rst), .d(bus.shcp), .lvl(shcp_s), .rise_c(shcp_rise_c)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_stcp (
    .clk(sys_clk), .rst(sys_rst), .d(bus.stcp), .lvl(stcp_s), .rise_c(stcp_rise_c)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_oe (
    .clk(sys_clk), .rst(sys_rst), .d(bus.oe), .lvl(oe_s), .rise_c(oe_rise_unused)
  );

  logic [ARM_W-1:0]      arm_cnt_q, arm_cnt_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  vld_q, vld_d;
  logic                  oe_act_q, oe_act_d;
`ifdef HC595_RX_CHK_EN
  logic                  err_q, err_d;
`endif

  logic armed_c;
  logic shift_c;
  logic latch_c;

  // Edges are ignored until the synchronizers have flushed out of reset.
  assign armed_c = (arm_cnt_q == ARM_DONE);
  assign shift_c = armed_c & shcp_rise_c;
  assign latch_c = armed_c & stcp_rise_c;

  // Next state: latch uses pre-shift shreg, then shift, counter bookkeeping.
  always_comb begin
    arm_cnt_d = arm_cnt_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    sel_d     = sel_q;
    seg_d     = seg_q;
    vld_d     = 1'b0;
    oe_act_d  = ~oe_s;
`ifdef HC595_RX_CHK_EN
    err_d     = err_q;
`endif

    if (!armed_c) begin
      arm_cnt_d = arm_cnt_q + ARM_W'(1);
    end

    if (latch_c) begin
      sel_d     = sel_from_frame(shreg_q);
      seg_d     = seg_from_frame(shreg_q);
      vld_d     = 1'b1;
      bit_cnt_d = '0;
`ifdef HC595_RX_CHK_EN
      if (bit_cnt_q != CNT_FULL) begin
        err_d = 1'b1;
      end
`endif
    end

    if (shift_c) begin
      shreg_d = {ds_s, shreg_q[FRAME_BITS-1:1]};
      if (latch_c) begin
        bit_cnt_d = CNT_W'(1);
      end else if (bit_cnt_q != CNT_MAX) begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      arm_cnt_q <= '0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      sel_q     <= '0;
      seg_q     <= '0;
      vld_q     <= 1'b0;
      oe_act_q  <= 1'b0;
`ifdef HC595_RX_CHK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      arm_cnt_q <= arm_cnt_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      sel_q     <= sel_d;
      seg_q     <= seg_d;
      vld_q     <= vld_d;
      oe_act_q  <= oe_act_d;
`ifdef HC595_RX_CHK_EN
      err_q     <= err_d;
`endif
    end
  end

  assign bus.sel       = sel_q;
  assign bus.seg       = seg_q;
  assign bus.frame_vld = vld_q;
  assign bus.oe_act    = oe_act_q;
`ifdef HC595_RX_CHK_EN
  assign bus.frame_err = err_q;
`else
  assign bus.frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_hc_595_rx.sv
// Directed bench for hc_595_rx; framing-error expectations follow HC595_RX_CHK_EN.
module tb_hc_595_rx;

`ifdef HC595_RX_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk;
  logic sys_rst;

  hc_595_rx_if bus();

  hc_595_rx #(.SYNC_STAGES(2)) dut (
    .sys_clk (clk),
    .sys_rst (sys_rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [13:0] m_sh;
  int          m_cnt;
  logic        m_err;
  logic [5:0]  last_sel;
  logic [7:0]  last_seg;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rev_seg(input logic [13:0] f);
    logic [7:0] s;
    for (int i = 0; i < 8; i++) s[7-i] = f[6+i];
    return s;
  endfunction

  // Reset with whatever serial levels are currently applied; checks reset values.
  task automatic do_reset(input string tag);
    sys_rst = 1'b1;
    repeat (3) tick();
    check_eq({tag, "_rst_sel"}, 16'(bus.sel), 16'h0);
    check_eq({tag, "_rst_seg"}, 16'(bus.seg), 16'h0);
    check_eq({tag, "_rst_vld"}, 16'(bus.frame_vld), 16'h0);
    check_eq({tag, "_rst_oeact"}, 16'(bus.oe_act), 16'h0);
    check_eq({tag, "_rst_err"}, 16'(bus.frame_err), 16'h0);
    sys_rst = 1'b0;
    m_sh = '0; m_cnt = 0; m_err = 1'b0;
    last_sel = '0; last_seg = '0;
  endtask

  task automatic send_bit(input logic b);
    bus.ds = b;
    bus.shcp = 1'b0;
    tick(); tick();
    bus.shcp = 1'b1;
    tick(); tick();
    m_sh = {b, m_sh[13:1]};
    if (m_cnt < 15) m_cnt++;
  endtask

  // Send the first nbits of a frame in wire order.
  task automatic send_frame(input logic [5:0] sel, input logic [7:0] seg, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (i < 6) send_bit(sel[i]);
      else       send_bit(seg[13-i]);
    end
    bus.shcp = 1'b0;
  endtask

  // stcp pulse; outputs must change on the third sampled cycle only.
  task automatic latch_check(input string tag, input logic [5:0] esel, input logic [7:0] eseg);
    if (CHK && m_cnt != 14) m_err = 1'b1;
    m_cnt = 0;
    bus.shcp = 1'b0;
    bus.stcp = 1'b1;
    tick(); tick();
    check_eq({tag, "_vld_early"}, 16'(bus.frame_vld), 16'h0);
    check_eq({tag, "_sel_early"}, 16'(bus.sel), 16'(last_sel));
    bus.stcp = 1'b0;
    tick();
    check_eq({tag, "_vld"}, 16'(bus.frame_vld), 16'h1);
    check_eq({tag, "_sel"}, 16'(bus.sel), 16'(esel));
    check_eq({tag, "_seg"}, 16'(bus.seg), 16'(eseg));
    tick();
    check_eq({tag, "_vld_1cyc"}, 16'(bus.frame_vld), 16'h0);
    check_eq({tag, "_err"}, 16'(bus.frame_err), 16'(m_err));
    tick();
    last_sel = esel; last_seg = eseg;
  endtask

  initial begin
    sys_rst  = 1'b1;
    bus.ds   = 1'b0;
    bus.shcp = 1'b0;
    bus.stcp = 1'b0;
    bus.oe   = 1'b1;
    m_sh = '0; m_cnt = 0; m_err = 1'b0;
    last_sel = '0; last_seg = '0;

    // Basic frame with exact latency.
    do_reset("a");
    repeat (5) tick();
    send_frame(6'b111110, 8'hC0, 14);
    latch_check("f1", 6'h3E, 8'hC0);

    // Short frame: latch takes shreg as-is, error flagged when checking is built in.
    send_frame(6'h15, 8'hA5, 13);
    latch_check("short", m_sh[5:0], rev_seg(m_sh));
    check_eq("short_err_sticky", 16'(bus.frame_err), 16'(CHK));

    // Lines held high through reset release: no shift, no strobe.
    bus.shcp = 1'b1;
    bus.stcp = 1'b1;
    do_reset("hold");
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("hold_vld", 16'(bus.frame_vld), 16'h0);
    end
    check_eq("hold_sel", 16'(bus.sel), 16'h0);
    check_eq("hold_seg", 16'(bus.seg), 16'h0);
    bus.shcp = 1'b0;
    bus.stcp = 1'b0;
    repeat (3) tick();

    // Full frame after that reset: counter must have stayed at 0.
    send_frame(6'h2D, 8'h3C, 14);
    latch_check("full", 6'h2D, 8'h3C);

    // Simultaneous shcp/stcp rise after 14 shifts: pre-shift frame latched.
    send_frame(6'h2A, 8'h5B, 14);
    bus.ds = 1'b1;
    tick(); tick();
    bus.shcp = 1'b1;
    bus.stcp = 1'b1;
    tick(); tick();
    check_eq("simul_vld_early", 16'(bus.frame_vld), 16'h0);
    bus.shcp = 1'b0;
    bus.stcp = 1'b0;
    tick();
    check_eq("simul_vld", 16'(bus.frame_vld), 16'h1);
    check_eq("simul_sel", 16'(bus.sel), 16'h2A);
    check_eq("simul_seg", 16'(bus.seg), 16'h5B);
    tick();
    check_eq("simul_vld_1cyc", 16'(bus.frame_vld), 16'h0);
    check_eq("simul_err", 16'(bus.frame_err), 16'h0);
    tick();
    last_sel = 6'h2A; last_seg = 8'h5B;
    m_sh = {1'b1, m_sh[13:1]};
    m_cnt = 1;
    // 13 more bits bring the counter to 14: no error expected.
    send_frame(6'h0F, 8'h81, 13);
    latch_check("after_simul", m_sh[5:0], rev_seg(m_sh));

    // Reset mid-frame, then a clean frame.
    send_frame(6'h3F, 8'hFF, 7);
    do_reset("mid");
    repeat (5) tick();
    check_eq("mid_sel_clr", 16'(bus.sel), 16'h0);
    send_frame(6'h11, 8'h96, 14);
    latch_check("mid_frame", 6'h11, 8'h96);

    // stcp with no shifts re-latches the same frame.
    latch_check("zero", 6'h11, 8'h96);

    // Output enable path; does not touch sel/seg.
    bus.oe = 1'b0;
    repeat (4) tick();
    check_eq("oe_on", 16'(bus.oe_act), 16'h1);
    bus.oe = 1'b1;
    tick(); tick();
    check_eq("oe_hold", 16'(bus.oe_act), 16'h1);
    tick();
    check_eq("oe_off", 16'(bus.oe_act), 16'h0);
    check_eq("oe_sel", 16'(bus.sel), 16'h11);
    check_eq("oe_seg", 16'(bus.seg), 16'h96);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
